// File: rtl/ifq_pkg.sv
// Shared types and constants for the IF->ID instruction queue.
// The exception-code width is shared with the fetch address-exception checker
// so both sides agree on the ExcCode field size.
package ifq_pkg;

    localparam int IFQ_DEPTH_DEFAULT = 4;
    localparam int IFQ_EXC_CODE_W    = 8;

    // One queued fetch: PC, instruction word and fetch-exception status.
    typedef struct packed {
        logic [31:0]               pc;
        logic [31:0]               instruct;
        logic                      except_set;
        logic [IFQ_EXC_CODE_W-1:0] exc_code;
    } ifq_entry_t;

    // Sequential next PC; wraps modulo 2^32.
    function automatic logic [31:0] ifq_next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifq_ram.sv
// Entry storage for the IF->ID queue: DEPTH x ifq_entry_t register array,
// one synchronous write port, one asynchronous read port, cleared on reset.
module ifq_ram
    import ifq_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH_DEFAULT,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  ifq_entry_t       wdata,
    input  logic [PTR_W-1:0] raddr,
    output ifq_entry_t       rdata
);

    ifq_entry_t mem [DEPTH];

    // Write port; all entries cleared on reset.
    // NOTE: the array is reset explicitly so that the head outputs read 0 after
    // reset instead of X; this costs a reset net per bit, which is accepted here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Instruction queue between the IF and ID pipeline stages.
// Circular buffer with valid/allowin handshakes on both sides and a
// single-cycle flush. allowin toward IF depends on the registered count only,
// so there is no combinational path from id_allowin_in to ifq_allowin_out.
// Optional feature: define IFQ_BYPASS_EN to let an instruction arriving at an
// empty queue pass straight through to ID in the same cycle.
module if_id_queue
    import ifq_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH_DEFAULT,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // IF side
    input  logic                      if_valid_in,
    input  logic [31:0]               if_PC_in,
    input  logic [31:0]               if_Instruct_in,
    input  logic                      if_ExceptSet_in,
    input  logic [IFQ_EXC_CODE_W-1:0] if_ExcCode_in,
    output logic                      ifq_allowin_out,
    // ID side
    input  logic                      id_allowin_in,
    output logic                      id_valid_out,
    output logic [31:0]               id_PC_out,
    output logic [31:0]               id_NPC_out,
    output logic [31:0]               id_Instruct_out,
    output logic                      id_ExceptSet_out,
    output logic [IFQ_EXC_CODE_W-1:0] id_ExcCode_out,
    // control / status
    input  logic                      flush_in,
    output logic [PTR_W:0]            ifq_count_out
);

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] rp;
    logic [PTR_W:0]   cnt;

    ifq_entry_t wr_entry;
    ifq_entry_t head_entry;
    ifq_entry_t out_entry;

    logic q_valid;
    logic push;
    logic wr_en;
    logic pop;
    logic id_valid;

    assign wr_entry = '{pc:         if_PC_in,
                        instruct:   if_Instruct_in,
                        except_set: if_ExceptSet_in,
                        exc_code:   if_ExcCode_in};

    assign ifq_allowin_out = (cnt != CNT_FULL);
    assign q_valid         = (cnt != '0) && !flush_in;
    assign push            = if_valid_in && ifq_allowin_out && !flush_in;

    ifq_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (wp),
        .wdata (wr_entry),
        .raddr (rp),
        .rdata (head_entry)
    );

    // Head selection and write/pop qualification (bypass path when enabled).
    // NOTE: every signal written here gets a default on entry so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        out_entry = head_entry;
        id_valid  = q_valid;
        wr_en     = push;
        pop       = q_valid && id_allowin_in;
`ifdef IFQ_BYPASS_EN
        if ((cnt == '0) && if_valid_in && !flush_in) begin
            out_entry = wr_entry;
            id_valid  = 1'b1;
            // Consumed by ID this cycle: never enters storage.
            if (id_allowin_in) begin
                wr_en = 1'b0;
            end
        end
`endif
    end

    // Pointer and occupancy update; flush empties the queue in one edge.
    // NOTE: state registers use non-blocking assignment so every always_ff
    // samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (flush_in) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr_en) begin
                wp <= wp + PTR_ONE;
            end
            if (pop) begin
                rp <= rp + PTR_ONE;
            end
            case ({wr_en, pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    assign id_valid_out     = id_valid;
    assign id_PC_out        = out_entry.pc;
    assign id_NPC_out       = ifq_next_pc(out_entry.pc);
    assign id_Instruct_out  = out_entry.instruct;
    assign id_ExceptSet_out = out_entry.except_set;
    assign id_ExcCode_out   = out_entry.exc_code;
    assign ifq_count_out    = cnt;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue (DEPTH=4). A per-cycle vector table
// covers the default (non-bypass) build; hand-written sequences cover async
// reset mid-operation, reset together with flush, and first-entry latency with
// or without IFQ_BYPASS_EN.
module tb_if_id_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid_in;
    logic [31:0] if_PC_in;
    logic [31:0] if_Instruct_in;
    logic        if_ExceptSet_in;
    logic [7:0]  if_ExcCode_in;
    logic        ifq_allowin_out;
    logic        id_allowin_in;
    logic        id_valid_out;
    logic [31:0] id_PC_out;
    logic [31:0] id_NPC_out;
    logic [31:0] id_Instruct_out;
    logic        id_ExceptSet_out;
    logic [7:0]  id_ExcCode_out;
    logic        flush_in;
    logic [2:0]  ifq_count_out;

    int n_checks = 0;
    int n_fail   = 0;

    if_id_queue #(.DEPTH(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_valid_in      (if_valid_in),
        .if_PC_in         (if_PC_in),
        .if_Instruct_in   (if_Instruct_in),
        .if_ExceptSet_in  (if_ExceptSet_in),
        .if_ExcCode_in    (if_ExcCode_in),
        .ifq_allowin_out  (ifq_allowin_out),
        .id_allowin_in    (id_allowin_in),
        .id_valid_out     (id_valid_out),
        .id_PC_out        (id_PC_out),
        .id_NPC_out       (id_NPC_out),
        .id_Instruct_out  (id_Instruct_out),
        .id_ExceptSet_out (id_ExceptSet_out),
        .id_ExcCode_out   (id_ExcCode_out),
        .flush_in         (flush_in),
        .ifq_count_out    (ifq_count_out)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus plus the outputs expected during that cycle
    // (sampled at the falling edge, before the state-updating rising edge).
    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        es;
        logic [7:0]  ec;
        logic        a;
        logic        f;
        logic        ea;
        logic        ev;
        logic [31:0] hpc;
        logic [31:0] hins;
        logic        hes;
        logic [7:0]  hec;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic es, input logic [7:0] ec, input logic a, input logic f);
        if_valid_in     = v;
        if_PC_in        = pc;
        if_Instruct_in  = ins;
        if_ExceptSet_in = es;
        if_ExcCode_in   = ec;
        id_allowin_in   = a;
        flush_in        = f;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " allowin"}, 32'(ifq_allowin_out), 32'd1);
        check({tag, " valid"},   32'(id_valid_out),    32'd0);
        check({tag, " count"},   32'(ifq_count_out),   32'd0);
        check({tag, " pc"},      id_PC_out,            32'd0);
        check({tag, " instr"},   id_Instruct_out,      32'd0);
        check({tag, " exc"},     32'(id_ExceptSet_out), 32'd0);
        check({tag, " code"},    32'(id_ExcCode_out),  32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 8'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        next_cycle();

`ifndef IFQ_BYPASS_EN
        // v, pc, ins, es, ec, a, f  |  ea, ev, hpc, hins, hes, hec, cnt
        // Back-to-back push with ID accepting: 1-cycle latency, count back to 0.
        vecs.push_back('{1, 32'hBFC00000, 32'h24010001, 0, 8'h00, 1, 0,  1, 0, 32'h0,        32'h0,        0, 8'h00, 0});
        vecs.push_back('{1, 32'hBFC00004, 32'h24020002, 0, 8'h00, 1, 0,  1, 1, 32'hBFC00000, 32'h24010001, 0, 8'h00, 1});
        vecs.push_back('{0, 32'h0,        32'h0,        0, 8'h00, 1, 0,  1, 1, 32'hBFC00004, 32'h24020002, 0, 8'h00, 1});
        vecs.push_back('{0, 32'h0,        32'h0,        0, 8'h00, 0, 0,  1, 0, 32'h0,        32'h0,        0, 8'h00, 0});
        // ID stalled, five pushes: fifth refused, then drain in order.
        vecs.push_back('{1, 32'h100, 32'hA0, 0, 8'h00, 0, 0,  1, 0, 32'h0,   32'h0,  0, 8'h00, 0});
        vecs.push_back('{1, 32'h104, 32'hA1, 0, 8'h00, 0, 0,  1, 1, 32'h100, 32'hA0, 0, 8'h00, 1});
        vecs.push_back('{1, 32'h108, 32'hA2, 0, 8'h00, 0, 0,  1, 1, 32'h100, 32'hA0, 0, 8'h00, 2});
        vecs.push_back('{1, 32'h10C, 32'hA3, 0, 8'h00, 0, 0,  1, 1, 32'h100, 32'hA0, 0, 8'h00, 3});
        vecs.push_back('{1, 32'h110, 32'hA4, 0, 8'h00, 0, 0,  0, 1, 32'h100, 32'hA0, 0, 8'h00, 4});
        vecs.push_back('{0, 32'h0,   32'h0,  0, 8'h00, 0, 0,  0, 1, 32'h100, 32'hA0, 0, 8'h00, 4});
        vecs.push_back('{0, 32'h0,   32'h0,  0, 8'h00, 1, 0,  0, 1, 32'h100, 32'hA0, 0, 8'h00, 4});
        vecs.push_back('{0, 32'h0,   32'h0,  0, 8'h00, 1, 0,  1, 1, 32'h104, 32'hA1, 0, 8'h00, 3});
        vecs.push_back('{0, 32'h0,   32'h0,  0, 8'h00, 1, 0,  1, 1, 32'h108, 32'hA2, 0, 8'h00, 2});
        vecs.push_back('{0, 32'h0,   32'h0,  0, 8'h00, 1, 0,  1, 1, 32'h10C, 32'hA3, 0, 8'h00, 1});
        vecs.push_back('{0, 32'h0,   32'h0,  0, 8'h00, 0, 0,  1, 0, 32'h0,   32'h0,  0, 8'h00, 0});
        // Full queue, push and pop together: push refused, count 3, allowin back.
        vecs.push_back('{1, 32'h200, 32'hB0, 0, 8'h00, 0, 0,  1, 0, 32'h0,   32'h0,  0, 8'h00, 0});
        vecs.push_back('{1, 32'h204, 32'hB1, 0, 8'h00, 0, 0,  1, 1, 32'h200, 32'hB0, 0, 8'h00, 1});
        vecs.push_back('{1, 32'h208, 32'hB2, 0, 8'h00, 0, 0,  1, 1, 32'h200, 32'hB0, 0, 8'h00, 2});
        vecs.push_back('{1, 32'h20C, 32'hB3, 0, 8'h00, 0, 0,  1, 1, 32'h200, 32'hB0, 0, 8'h00, 3});
        vecs.push_back('{1, 32'h210, 32'hB4, 0, 8'h00, 1, 0,  0, 1, 32'h200, 32'hB0, 0, 8'h00, 4});
        vecs.push_back('{0, 32'h0,   32'h0,  0, 8'h00, 0, 0,  1, 1, 32'h204, 32'hB1, 0, 8'h00, 3});
        // Flush at count 3 with a push present: valid drops, push dropped.
        vecs.push_back('{1, 32'h300, 32'hC0, 0, 8'h00, 1, 1,  1, 0, 32'h0,   32'h0,  0, 8'h00, 3});
        vecs.push_back('{0, 32'h0,   32'h0,  0, 8'h00, 1, 0,  1, 0, 32'h0,   32'h0,  0, 8'h00, 0});
        vecs.push_back('{0, 32'h0,   32'h0,  0, 8'h00, 0, 0,  1, 0, 32'h0,   32'h0,  0, 8'h00, 0});
        // Exception entry is queued untouched.
        vecs.push_back('{1, 32'hBFC00002, 32'h0, 1, 8'h04, 0, 0,  1, 0, 32'h0,        32'h0, 0, 8'h00, 0});
        vecs.push_back('{0, 32'h0,        32'h0, 0, 8'h00, 1, 0,  1, 1, 32'hBFC00002, 32'h0, 1, 8'h04, 1});
        vecs.push_back('{0, 32'h0,        32'h0, 0, 8'h00, 0, 0,  1, 0, 32'h0,        32'h0, 0, 8'h00, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].pc, vecs[i].ins, vecs[i].es, vecs[i].ec, vecs[i].a, vecs[i].f);
            @(negedge clk);
            check($sformatf("v%0d allowin", i), 32'(ifq_allowin_out), 32'(vecs[i].ea));
            check($sformatf("v%0d valid", i),   32'(id_valid_out),    32'(vecs[i].ev));
            check($sformatf("v%0d count", i),   32'(ifq_count_out),   32'(vecs[i].cnt));
            if (vecs[i].ev) begin
                check($sformatf("v%0d pc", i),    id_PC_out,              vecs[i].hpc);
                check($sformatf("v%0d npc", i),   id_NPC_out,             vecs[i].hpc + 32'd4);
                check($sformatf("v%0d instr", i), id_Instruct_out,        vecs[i].ins == 32'h0 ? vecs[i].hins : vecs[i].hins);
                check($sformatf("v%0d exc", i),   32'(id_ExceptSet_out),  32'(vecs[i].hes));
                check($sformatf("v%0d code", i),  32'(id_ExcCode_out),    32'(vecs[i].hec));
            end
            next_cycle();
        end
`endif

        // Asynchronous reset mid-operation: entries lost at once, not at an edge.
        drive(1'b1, 32'h500, 32'hE0, 1'b0, 8'h00, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 32'h504, 32'hE1, 1'b0, 8'h00, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        check("pre-reset count", 32'(ifq_count_out), 32'd2);
        rst_n = 1'b0;
        #1;
        check_reset_state("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // Reset together with flush on a non-empty queue: reset end state.
        drive(1'b1, 32'h600, 32'hF0, 1'b1, 8'h0C, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 32'h604, 32'hF1, 1'b0, 8'h00, 1'b0, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("reset+flush");
        drive(1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        next_cycle();
        check_reset_state("after reset+flush");

        // First-entry latency on an empty queue with ID ready.
        drive(1'b1, 32'h400, 32'hD0, 1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
`ifdef IFQ_BYPASS_EN
        check("bypass valid same cycle", 32'(id_valid_out), 32'd1);
        check("bypass pc", id_PC_out, 32'h400);
        check("bypass npc", id_NPC_out, 32'h404);
        check("bypass instr", id_Instruct_out, 32'hD0);
`else
        check("no-bypass valid same cycle", 32'(id_valid_out), 32'd0);
`endif
        next_cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
`ifdef IFQ_BYPASS_EN
        check("bypass count stays 0", 32'(ifq_count_out), 32'd0);
        check("bypass valid next cycle", 32'(id_valid_out), 32'd0);
`else
        check("latency valid next cycle", 32'(id_valid_out), 32'd1);
        check("latency pc", id_PC_out, 32'h400);
        check("latency instr", id_Instruct_out, 32'hD0);
        check("latency count", 32'(ifq_count_out), 32'd1);
`endif
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue between the IF stage and the ID stage of the 5-stage MIPS pipeline. It buffers fetched instructions with their PC and fetch-exception status so that ID stalls do not need to propagate combinationally back into fetch. It presents a valid/allowin handshake on both sides, matching the stage protocol. It is emptied in one cycle by a flush (branch redirect or exception) from downstream.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2
- PTR_W, $clog2(DEPTH), pointer width (derived)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_valid_in  in  1  IF presents a fetched instruction this cycle
- if_PC_in  in  32  PC of the fetched instruction
- if_Instruct_in  in  32  instruction word
- if_ExceptSet_in  in  1  fetch address exception flag
- if_ExcCode_in  in  8  fetch exception code
- ifq_allowin_out  out  1  queue accepts a push this cycle (not full)
- id_allowin_in  in  1  ID consumes the head entry this cycle
- id_valid_out  out  1  head entry valid
- id_PC_out, id_NPC_out  out  32  head PC; head PC + 4 (mod 2^32)
- id_Instruct_out  out  32  head instruction
- id_ExceptSet_out  out  1  head exception flag
- id_ExcCode_out  out  8  head exception code
- flush_in  in  1  discard all entries
- ifq_count_out  out  PTR_W+1  current occupancy

## Operation
- Storage: circular buffer, DEPTH entries of {PC, Instruct, ExceptSet, ExcCode}; write pointer wp, read pointer rp, occupancy cnt, each PTR_W / PTR_W+1 bits; pointers wrap modulo DEPTH.
- push = if_valid_in && ifq_allowin_out && !flush_in; writes entry at wp, wp <= wp+1.
- pop = id_valid_out && id_allowin_in; rp <= rp+1.
- cnt <= cnt + push - pop; push and pop in the same cycle leave cnt unchanged.
- ifq_allowin_out = (cnt != DEPTH), derived from registered cnt only; a pop in the same cycle does not re-open a full queue (no combinational path id_allowin_in -> ifq_allowin_out).
- id_valid_out = (cnt != 0) && !flush_in. Head outputs are driven from entry rp.
- Flush: wp, rp and cnt cleared at the next edge; any push in the flush cycle is dropped; storage contents need not be cleared.
- Exception entries are queued like normal entries; the queue never interprets them.

## Timing
- Reset (async assert, sync-free release): wp=rp=cnt=0; ifq_allowin_out=1; id_valid_out=0; ifq_count_out=0; all head data outputs 0 (storage reset to 0).
- Push-to-visible latency: 1 cycle (entry pushed at edge N is on id_* outputs after edge N).
- Full: ifq_allowin_out=0 for the whole cycle cnt==DEPTH; simultaneous IF valid is ignored.
- Empty: id_valid_out=0; pop has no effect even if id_allowin_in=1.
- Reset asserted mid-operation: all state cleared immediately; in-flight entries lost.
- flush_in and reset together: reset dominates (identical end state).

## Configuration
- IFQ_BYPASS_EN defined: when cnt==0 and if_valid_in && !flush_in, the IF inputs drive id_* combinationally with id_valid_out=1; if id_allowin_in is also 1 the instruction is consumed without being written (no wp/cnt change); otherwise it is written normally. Latency 0 on empty queue.
- Not defined: no bypass path; latency always 1 cycle as above.

## Structure
- Shared package ifq_pkg: typedef ifq_entry_t {PC[31:0], Instruct[31:0], ExceptSet, ExcCode[7:0]}; constant IFQ_DEPTH_DEFAULT=4; exception-code width constant shared with the address-exception checker.
- One sub-module: ifq_ram, DEPTH x ifq_entry_t register array with one write port and one async read port, reset to zero.
- Top holds pointers, counter, handshake logic and the IFQ_BYPASS_EN mux.

## Test plan
- Reset then push PC 0xBFC00000, 0xBFC00004, instr 0x24010001/0x24020002 with id_allowin_in=1 -> each appears on id_* one cycle later, id_NPC_out=0xBFC00004/0xBFC00008, count returns to 0.
- id_allowin_in=0, push 5 entries with DEPTH=4 -> ifq_allowin_out drops after 4th push, 5th not stored, count=4; release ID -> 4 entries pop in order.
- Full queue with push and pop same cycle -> push refused, count 3 after edge, allowin 1 next cycle.
- Count=3, flush_in=1 with if_valid_in=1 -> id_valid_out=0 that cycle, count=0 next cycle, flushed push absent.
- Push entry with ExceptSet=1, ExcCode=0x04 at PC 0xBFC00002 -> same flag/code/PC at head.
- IFQ_BYPASS_EN, empty queue, if_valid_in=1, id_allowin_in=1 -> id_valid_out=1 same cycle, count stays 0; without macro -> id_valid_out=0 that cycle, 1 next.
